// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the goto-position counter controller.
package count_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Modular distance a - b on the counter ring.
  function automatic logic [CNT_W-1:0] ring_dist(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/count_goto_ctrl_if.sv
// Request/status bundle between a move requester and count_goto_ctrl.
interface count_goto_ctrl_if;
  import count_ctrl_pkg::*;

  logic             start;
  logic [CNT_W-1:0] target;
  logic             abort;
  logic [CNT_W-1:0] pos;
  logic             busy;
  logic             done;
  logic             down;
  logic             step2;

  modport master (output start, target, abort,
                  input  pos, busy, done, down, step2);
  modport slave  (input  start, target, abort,
                  output pos, busy, done, down, step2);
endinterface

// File: rtl/count4_core.sv
// Position register: steps up or down by 1 or 2 (mod 16) while enabled.
module count4_core
  import count_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step2,
  input  logic             down,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] stp_s;

  assign stp_s = step2 ? 4'd2 : 4'd1;

  // Position update; wrap-around falls out of the 4-bit arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (en) begin
      q <= down ? (q - stp_s) : (q + stp_s);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/count_goto_ctrl.sv
// Moves a 4-bit position to a requested target along the shorter ring direction,
// stepping by 2 while far away, with abort and a one-cycle done pulse.
module count_goto_ctrl
  import count_ctrl_pkg::*;
#(
  parameter bit ALLOW_STEP2 = 1'b1
)(
  input  logic               clk,
  input  logic               rst,
  count_goto_ctrl_if.slave   bus
);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] tgt_r;
  logic             down_r;
  logic [CNT_W-1:0] pos_s;
  logic [CNT_W-1:0] du_s, dd_s, rem_s, stp_s;
  logic             req_s, step2_s, en_s;

  assign du_s  = ring_dist(bus.target, pos_s);
  assign dd_s  = ring_dist(pos_s, bus.target);
  assign req_s = (state_r == IDLE) && bus.start && !bus.abort;
  assign rem_s = down_r ? ring_dist(pos_s, tgt_r) : ring_dist(tgt_r, pos_s);

  // step2 is a function of the current state only, so it is 0 outside MOVE.
  assign step2_s = (state_r == MOVE) && (ALLOW_STEP2 == 1'b1) && (rem_s >= 4'd2);
  assign stp_s   = step2_s ? 4'd2 : 4'd1;
  // Abort must freeze pos on the same edge that leaves MOVE.
  assign en_s    = (state_r == MOVE) && !bus.abort;

  count4_core u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (en_s),
    .step2 (step2_s),
    .down  (down_r),
    .q     (pos_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = (bus.target == pos_s) ? DONE : MOVE;
        end else begin
          state_s = IDLE;
        end
      end
      MOVE: begin
        if (bus.abort) begin
          state_s = IDLE;
        end else if (rem_s == stp_s) begin
          state_s = DONE;
        end else begin
          state_s = MOVE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus target/direction capture on an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tgt_r   <= 4'd0;
      down_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (req_s) begin
        tgt_r  <= bus.target;
        down_r <= (du_s > dd_s);
      end else begin
        tgt_r  <= tgt_r;
        down_r <= down_r;
      end
    end
  end

  assign bus.pos   = pos_s;
  assign bus.busy  = (state_r != IDLE);
  assign bus.done  = (state_r == DONE);
  assign bus.down  = down_r;
  assign bus.step2 = step2_s;

endmodule

// File: tb/tb_count_goto_ctrl.sv
// Directed bench for count_goto_ctrl; u0 uses step-by-2, u1 is step-by-1 only.
module tb_count_goto_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  count_goto_ctrl_if b0 ();
  count_goto_ctrl_if b1 ();

  count_goto_ctrl #(.ALLOW_STEP2(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  count_goto_ctrl #(.ALLOW_STEP2(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    tests++; if (b0.pos !== 4'd0)  begin fails++; $display("FAIL rst_pos: got %0d expected 0", b0.pos); end
    tests++; if (b0.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b expected 0", b0.busy); end
    tests++; if (b0.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b expected 0", b0.done); end
    tests++; if (b0.step2 !== 1'b0 || b0.down !== 1'b0) begin fails++; $display("FAIL rst_step2_down: got %0b/%0b expected 0/0", b0.step2, b0.down); end
    @(negedge clk);
    rst = 1'b0; b0.start = 1'b1; b0.target = 4'd0;
    @(negedge clk);
    tests++; if (b0.done !== 1'b1 || b0.busy !== 1'b1) begin fails++; $display("FAIL first_start_done: got done=%0b busy=%0b expected 1/1", b0.done, b0.busy); end
    tests++; if (b0.pos !== 4'd0) begin fails++; $display("FAIL first_start_pos: got %0d expected 0", b0.pos); end
    b0.start = 1'b0;
    @(negedge clk);
    tests++; if (b0.done !== 1'b0 || b0.busy !== 1'b0) begin fails++; $display("FAIL first_start_idle: got done=%0b busy=%0b expected 0/0", b0.done, b0.busy); end
  endtask

  task automatic test_up;
    logic [3:0] ep [3];
    logic       es2 [3];
    ep  = '{4'd2, 4'd4, 4'd5};
    es2 = '{1'b1, 1'b1, 1'b0};
    b0.start = 1'b1; b0.target = 4'd5;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.down !== 1'b0 || b0.busy !== 1'b1) begin fails++; $display("FAIL up_dir: got down=%0b busy=%0b expected 0/1", b0.down, b0.busy); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (b0.step2 !== es2[i]) begin fails++; $display("FAIL up_step2[%0d]: got %0b expected %0b", i, b0.step2, es2[i]); end
      tests++; if (b0.done !== 1'b0) begin fails++; $display("FAIL up_early_done[%0d]: got 1 expected 0", i); end
      @(negedge clk);
      tests++; if (b0.pos !== ep[i]) begin fails++; $display("FAIL up_pos[%0d]: got %0d expected %0d", i, b0.pos, ep[i]); end
    end
    tests++; if (b0.done !== 1'b1) begin fails++; $display("FAIL up_done: got %0b expected 1", b0.done); end
    @(negedge clk);
    tests++; if (b0.done !== 1'b0 || b0.busy !== 1'b0 || b0.pos !== 4'd5) begin fails++; $display("FAIL up_end: got done=%0b busy=%0b pos=%0d expected 0/0/5", b0.done, b0.busy, b0.pos); end
  endtask

  task automatic test_down;
    b0.start = 1'b1; b0.target = 4'd2;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.down !== 1'b1 || b0.step2 !== 1'b1) begin fails++; $display("FAIL down_dir: got down=%0b step2=%0b expected 1/1", b0.down, b0.step2); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd3) begin fails++; $display("FAIL down_pos0: got %0d expected 3", b0.pos); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd2 || b0.done !== 1'b1) begin fails++; $display("FAIL down_pos1: got pos=%0d done=%0b expected 2/1", b0.pos, b0.done); end
    @(negedge clk);
    tests++; if (b0.busy !== 1'b0 || b0.down !== 1'b1) begin fails++; $display("FAIL down_end: got busy=%0b down=%0b expected 0/1", b0.busy, b0.down); end
  endtask

  task automatic test_wrap;
    // 2 -> 14 goes down through 0, then 14 -> 1 goes up through 15/0.
    b0.start = 1'b1; b0.target = 4'd14;
    @(negedge clk);
    b0.start = 1'b0;
    @(negedge clk);
    tests++; if (b0.pos !== 4'd0) begin fails++; $display("FAIL wrap_dn_pos0: got %0d expected 0", b0.pos); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd14 || b0.done !== 1'b1) begin fails++; $display("FAIL wrap_dn_pos1: got pos=%0d done=%0b expected 14/1", b0.pos, b0.done); end
    @(negedge clk);
    b0.start = 1'b1; b0.target = 4'd1;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.down !== 1'b0) begin fails++; $display("FAIL wrap_up_dir: got %0b expected 0", b0.down); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd0) begin fails++; $display("FAIL wrap_up_pos0: got %0d expected 0", b0.pos); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd1 || b0.done !== 1'b1) begin fails++; $display("FAIL wrap_up_pos1: got pos=%0d done=%0b expected 1/1", b0.pos, b0.done); end
    @(negedge clk);
  endtask

  task automatic test_tie;
    logic [3:0] e0;
    b0.start = 1'b1; b0.target = 4'd0;
    @(negedge clk);
    b0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (b0.pos !== 4'd0 || b0.busy !== 1'b0) begin fails++; $display("FAIL tie_setup: got pos=%0d busy=%0b expected 0/0", b0.pos, b0.busy); end
    b0.start = 1'b1; b0.target = 4'd8;
    b1.start = 1'b1; b1.target = 4'd8;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) begin
        b0.start = 1'b0; b1.start = 1'b0;
        tests++; if (b0.down !== 1'b0 || b1.down !== 1'b0) begin fails++; $display("FAIL tie_dir: got %0b/%0b expected 0/0", b0.down, b1.down); end
        tests++; if (b1.step2 !== 1'b0) begin fails++; $display("FAIL tie_step1_only: got %0b expected 0", b1.step2); end
      end
      e0 = (j <= 5) ? 4'(2 * (j - 1)) : 4'd8;
      tests++; if (b0.pos !== e0 || b0.done !== (j == 5)) begin fails++; $display("FAIL tie_s2[%0d]: got pos=%0d done=%0b expected %0d/%0b", j, b0.pos, b0.done, e0, (j == 5)); end
      tests++; if (b1.pos !== 4'(j - 1) || b1.done !== (j == 9)) begin fails++; $display("FAIL tie_s1[%0d]: got pos=%0d done=%0b expected %0d/%0b", j, b1.pos, b1.done, j - 1, (j == 9)); end
    end
    @(negedge clk);
    tests++; if (b0.busy !== 1'b0 || b1.busy !== 1'b0) begin fails++; $display("FAIL tie_end: got busy=%0b/%0b expected 0/0", b0.busy, b1.busy); end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    b0.start = 1'b1; b0.target = 4'd0;
    @(negedge clk);
    b0.start = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (b0.done === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b1 || b0.pos !== 4'd0) begin fails++; $display("FAIL abort_setup: got seen=%0b pos=%0d expected 1/0", seen, b0.pos); end
    @(negedge clk);
    b0.start = 1'b1; b0.target = 4'd9;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.down !== 1'b1) begin fails++; $display("FAIL abort_dir: got %0b expected 1", b0.down); end
    @(negedge clk);
    tests++; if (b0.pos !== 4'd14) begin fails++; $display("FAIL abort_pos0: got %0d expected 14", b0.pos); end
    // Start during MOVE must not retarget to 13.
    b0.start = 1'b1; b0.target = 4'd13;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.pos !== 4'd12) begin fails++; $display("FAIL busy_start_ignored: got %0d expected 12", b0.pos); end
    b0.abort = 1'b1;
    @(negedge clk);
    b0.abort = 1'b0;
    tests++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.pos !== 4'd12) begin fails++; $display("FAIL abort_idle: got busy=%0b done=%0b pos=%0d expected 0/0/12", b0.busy, b0.done, b0.pos); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (b0.done !== 1'b0 || b0.pos !== 4'd12) begin fails++; $display("FAIL abort_hold[%0d]: got done=%0b pos=%0d expected 0/12", k, b0.done, b0.pos); end
    end
    b0.start = 1'b1; b0.abort = 1'b1; b0.target = 4'd5;
    @(negedge clk);
    b0.start = 1'b0; b0.abort = 1'b0;
    tests++; if (b0.busy !== 1'b0 || b0.pos !== 4'd12) begin fails++; $display("FAIL start_abort_idle: got busy=%0b pos=%0d expected 0/12", b0.busy, b0.pos); end
  endtask

  task automatic test_reset_mid;
    b0.start = 1'b1; b0.target = 4'd10;
    @(negedge clk);
    b0.start = 1'b0;
    tests++; if (b0.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %0b expected 1", b0.busy); end
    #1 rst = 1'b1;
    #1;
    tests++; if (b0.pos !== 4'd0 || b0.busy !== 1'b0 || b0.step2 !== 1'b0) begin fails++; $display("FAIL rmid_async: got pos=%0d busy=%0b step2=%0b expected 0/0/0", b0.pos, b0.busy, b0.step2); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (b0.done !== 1'b0 || b0.busy !== 1'b0 || b0.pos !== 4'd0) begin fails++; $display("FAIL rmid_after[%0d]: got done=%0b busy=%0b pos=%0d expected 0/0/0", k, b0.done, b0.busy, b0.pos); end
    end
  endtask

  initial begin
    rst = 1'b0;
    b0.start = 1'b0; b0.target = 4'd0; b0.abort = 1'b0;
    b1.start = 1'b0; b1.target = 4'd0; b1.abort = 1'b0;
    test_reset;
    test_up;
    test_down;
    test_wrap;
    test_tie;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_goto_ctrl.md
COUNT_GOTO_CTRL -- requirements
Module: count_goto_ctrl

Interface
REQ-001 Parameter: ALLOW_STEP2, default 1, enables step-by-2 moves; 0 forces step-by-1.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a move; sampled only in IDLE.
REQ-005 target  input  4  destination position, captured with start.
REQ-006 abort  input  1  cancel the move in progress.
REQ-007 pos  output  4  current counter position.
REQ-008 busy  output  1  high in MOVE and DONE.
REQ-009 done  output  1  one-cycle pulse on move completion.
REQ-010 down  output  1  direction of the current or last move (1 = decrement).
REQ-011 step2  output  1  the step applied at the next edge is 2 (else 1).

Function
REQ-012 FSM states: IDLE, MOVE, DONE.
REQ-013 IDLE: start=1 captures target into tgt_q. Next state is DONE if target==pos, else MOVE.
REQ-014 IDLE direction choice: du=(target-pos) mod 16, dd=(pos-target) mod 16; down=0 if du<=dd, else down=1. The tie at 8 goes up.
REQ-015 down is latched at start and held constant through MOVE and DONE.
REQ-016 MOVE: every edge, pos <= pos +/- stp mod 16.
  - stp=2 when ALLOW_STEP2=1 and remaining distance >=2.
  - Otherwise stp=1.
REQ-017 Remaining distance = (tgt_q-pos) mod 16 when up, (pos-tgt_q) mod 16 when down.
REQ-018 step2 is combinational from state/remaining. It is 0 outside MOVE.
REQ-019 MOVE exit: the edge that makes pos==tgt_q also moves the state to DONE.
  - MOVE lasts ceil(d/2) cycles (ALLOW_STEP2=1) or d cycles (ALLOW_STEP2=0).
REQ-020 DONE lasts exactly one cycle with done=1, then IDLE. pos holds.
REQ-021 Wrap-around: arithmetic is modulo 16 in both directions (15+1->0, 0-2->14).
REQ-022 start while busy is ignored. No queuing.
REQ-023 abort=1 in MOVE: next edge goes to IDLE, pos holds its current value, and no done pulse is produced.
REQ-024 abort in IDLE or DONE has no effect.
REQ-025 abort and start asserted together in IDLE: the request is ignored and the block stays in IDLE.
REQ-026 pos changes only in MOVE.

Reset
REQ-027 rst=1 immediately forces: IDLE, pos=0, tgt_q=0, down=0, done=0, busy=0, step2=0.
REQ-028 Reset mid-move abandons the move. No done pulse follows release.
REQ-029 First start is accepted on the first rising edge with rst=0.

Structure
REQ-030 Shared package count_ctrl_pkg holds:
  - the state enum typedef (IDLE, MOVE, DONE);
  - the width constant CNT_W=4.
REQ-031 Position register is one sub-module, count4_core.
  - Inputs: clk, rst, en, step2, down.
  - Output: 4-bit q, updating q +/- (1 or 2) when en=1.
  - count_goto_ctrl instances it once and drives en=(state==MOVE).
REQ-032 Distance and direction logic stays in count_goto_ctrl.

Verification
REQ-033 Reset:
  - assert rst mid-cycle -> pos=0, busy=0, done=0 without waiting for a clock edge;
  - release rst, start target=0 -> DONE next cycle, done pulse, pos stays 0.
REQ-034 Up move:
  - stimulus: pos=0, start target=5;
  - response: down=0, step2 1,1,0, pos 2,4,5 over 3 MOVE cycles, then done=1 for one cycle, then busy=0.
REQ-035 Down move with wrap choice:
  - pos=5, target=2: dd=3, down=1, pos 3,2, then done.
  - pos=14, target=1: up, pos 0,1 (wrap), then done.
REQ-036 Tie:
  - pos=0, target=8 -> up, 4 MOVE cycles, pos 2,4,6,8.
  - With ALLOW_STEP2=0 -> 8 MOVE cycles.
REQ-037 Abort and ignored start:
  - pos=0, target=9 (down, dd=7), abort after 2 MOVE cycles -> pos=12, IDLE, no done.
  - start pulsed during MOVE -> no effect on tgt_q.
REQ-038 Reset mid-move: rst during MOVE toward 10 -> pos=0, IDLE, and no done for 5 cycles after release.
